pc_fetch_stage: RTL and testbench

//   Consumer of the next-PC value: holds the fetch PC register and drives the instruction-memory request.

---
 rtl/pc_fetch_stage_pkg.sv | 23 ++
 rtl/pc_fetch_stage_if_id_reg.sv | 56 +++++
 rtl/pc_fetch_stage.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, reset defaults and PC arithmetic.
package pc_fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_HELD    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   // Word-aligned sequential successor; wraps modulo 2^32.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module pc_fetch_stage_if_id_reg
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

   // Load wins over bubble; neither means hold (stall).
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         instr_d = instr_in;
      end else if (bubble) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else begin
         valid_d = valid_q;
      end
   end

   // IF/ID state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0000_0000;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the fetch PC, drives the IM request and fills IF/ID, absorbing IM latency,
// stalls and redirects without losing or duplicating instructions.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_Next,
   input  logic        Redirect,
   input  logic        Stall,
   output logic        IM_Req,
   output logic [31:0] IM_Addr,
   input  logic        IM_Ready,
   input  logic [31:0] IM_Rdata,
   output logic        IFID_Valid,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_Instr
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_f_q, pc_f_d;
   logic [31:0]  redir_pc_q, redir_pc_d;
   logic [31:0]  buf_pc_q, buf_pc_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic         ifid_load_s, ifid_bubble_s;
   logic [31:0]  ifid_pc_s, ifid_instr_s;
   logic [31:0]  target_s;

   assign target_s = align_pc(PC_Next);

   // Next-state and IF/ID control; Stall always dominates Redirect.
   always_comb begin
      state_d       = state_q;
      pc_f_d        = pc_f_q;
      redir_pc_d    = redir_pc_q;
      buf_pc_d      = buf_pc_q;
      buf_instr_d   = buf_instr_q;
      ifid_load_s   = 1'b0;
      ifid_bubble_s = 1'b0;
      ifid_pc_s     = pc_f_q;
      ifid_instr_s  = IM_Rdata;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (IM_Ready) begin
               if (Stall) begin
                  buf_pc_d    = pc_f_q;
                  buf_instr_d = IM_Rdata;
                  state_d     = ST_HELD;
               end else if (Redirect) begin
                  ifid_bubble_s = 1'b1;
                  pc_f_d        = target_s;
               end else begin
                  ifid_load_s = 1'b1;
                  pc_f_d      = seq_pc(pc_f_q);
               end
            end else begin
               if (Stall) begin
                  state_d = ST_FETCH;
               end else if (Redirect) begin
                  redir_pc_d    = target_s;
                  ifid_bubble_s = 1'b1;
                  state_d       = ST_DISCARD;
               end else begin
                  ifid_bubble_s = 1'b1;
               end
            end
         end
         ST_HELD: begin
            if (Stall) begin
               state_d = ST_HELD;
            end else if (Redirect) begin
               ifid_bubble_s = 1'b1;
               pc_f_d        = target_s;
               state_d       = ST_FETCH;
            end else begin
               ifid_load_s  = 1'b1;
               ifid_pc_s    = buf_pc_q;
               ifid_instr_s = buf_instr_q;
               pc_f_d       = seq_pc(buf_pc_q);
               state_d      = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            // The old-path request stays on the bus until it completes; only then switch address.
            ifid_bubble_s = !Stall;
            if (!Stall && Redirect) begin
               redir_pc_d = target_s;
            end else begin
               redir_pc_d = redir_pc_q;
            end
            if (IM_Ready) begin
               pc_f_d  = redir_pc_d;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DISCARD;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Fetch-side state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_BOOT;
         pc_f_q      <= RESET_PC;
         redir_pc_q  <= 32'h0000_0000;
         buf_pc_q    <= 32'h0000_0000;
         buf_instr_q <= NOP_INSTR;
      end else begin
         state_q     <= state_d;
         pc_f_q      <= pc_f_d;
         redir_pc_q  <= redir_pc_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
      end
   end

   assign IM_Req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
   assign IM_Addr = pc_f_q;

   pc_fetch_stage_if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (reset),
      .load     (ifid_load_s),
      .bubble   (ifid_bubble_s),
      .pc_in    (ifid_pc_s),
      .instr_in (ifid_instr_s),
      .valid_o  (IFID_Valid),
      .pc_o     (IFID_PC),
      .instr_o  (IFID_Instr)
   );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: directed cycles push expected IF/ID entries; a monitor pops them.
module tb_pc_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_Next;
   logic        Redirect;
   logic        Stall;
   logic        IM_Req;
   logic [31:0] IM_Addr;
   logic        IM_Ready;
   logic [31:0] IM_Rdata;
   logic        IFID_Valid;
   logic [31:0] IFID_PC;
   logic [31:0] IFID_Instr;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];

   pc_fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .PC_Next    (PC_Next),
      .Redirect   (Redirect),
      .Stall      (Stall),
      .IM_Req     (IM_Req),
      .IM_Addr    (IM_Addr),
      .IM_Ready   (IM_Ready),
      .IM_Rdata   (IM_Rdata),
      .IFID_Valid (IFID_Valid),
      .IFID_PC    (IFID_PC),
      .IFID_Instr (IFID_Instr)
   );

   always #5 clk = ~clk;

   // Instruction word the bench's memory model returns for an address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive inputs at negedge, check request side, push expected IF/ID entry.
   task automatic step(input logic rdy, input logic stl, input logic rdr, input logic [31:0] nxt,
                       input logic [31:0] exp_addr, input logic exp_req,
                       input logic push, input logic [31:0] push_pc);
      @(negedge clk);
      IM_Ready = rdy;
      Stall    = stl;
      Redirect = rdr;
      PC_Next  = nxt;
      IM_Rdata = word_at(exp_addr);
      #1;
      check32("im_req", {31'd0, IM_Req}, {31'd0, exp_req});
      if (exp_req) check32("im_addr", IM_Addr, exp_addr);
      if (push) exp_q.push_back({push_pc, word_at(push_pc)});
      @(posedge clk);
      #1;
   endtask

   // Monitor: a new IF/ID entry appears after any unstalled edge that leaves IFID_Valid=1.
   always @(posedge clk) begin
      logic st, rs;
      logic [63:0] e;
      st = Stall;
      rs = reset;
      #1;
      if (!rs && !st && IFID_Valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ifid_unexpected: got pc %h instr %h expected no entry", IFID_PC, IFID_Instr);
         end else begin
            e = exp_q.pop_front();
            check32("ifid_pc", IFID_PC, e[63:32]);
            check32("ifid_instr", IFID_Instr, e[31:0]);
         end
      end
   end

   initial begin
      reset = 1'b1; PC_Next = 32'h0; Redirect = 1'b0; Stall = 1'b0;
      IM_Ready = 1'b0; IM_Rdata = 32'h0;
      #3;
      check32("rst_req", {31'd0, IM_Req}, 32'd0);
      check32("rst_valid", {31'd0, IFID_Valid}, 32'd0);
      check32("rst_ifid_pc", IFID_PC, 32'h0);
      check32("rst_ifid_instr", IFID_Instr, 32'h0);
      @(posedge clk); #1 reset = 1'b0;

      // 1: zero-wait sequential fetch
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3000, 1'b1, 1'b1, 32'h3000);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3004, 1'b1, 1'b1, 32'h3004);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3008, 1'b1, 1'b1, 32'h3008);

      // 2: stall on a completed response for 3 cycles
      step(1'b1, 1'b1, 1'b0, 32'h0, 32'h300C, 1'b1, 1'b0, 32'h0);
      check32("held_ifid_pc", IFID_PC, 32'h3008);
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check32("held_ifid_valid", {31'd0, IFID_Valid}, 32'd1);
      check32("held_ifid_pc2", IFID_PC, 32'h3008);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300C);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3010, 1'b1, 1'b1, 32'h3010);

      // 3: redirect with a completed response
      step(1'b1, 1'b0, 1'b1, 32'h3400, 32'h3014, 1'b1, 1'b0, 32'h0);
      check32("redir_bubble", {31'd0, IFID_Valid}, 32'd0);
      check32("redir_nop", IFID_Instr, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3400, 1'b1, 1'b1, 32'h3400);

      // 4: redirect while IM is slow; old address held until the response
      step(1'b0, 1'b0, 1'b1, 32'h3400, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3400, 1'b1, 1'b1, 32'h3400);
      // newer redirect coinciding with the response wins
      step(1'b0, 1'b0, 1'b1, 32'h3500, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h3602, 32'h3404, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3600, 1'b1, 1'b1, 32'h3600);

      // 5: redirect under stall ignored, then honoured; PC wrap
      step(1'b0, 1'b1, 1'b1, 32'h3800, 32'h3604, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h3800, 32'h3604, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h3800, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000);

      // 6: reset during DISCARD
      step(1'b0, 1'b0, 1'b1, 32'h3400, 32'h0000_0004, 1'b1, 1'b0, 32'h0);
      #2 reset = 1'b1;
      #1;
      check32("mid_rst_req", {31'd0, IM_Req}, 32'd0);
      check32("mid_rst_valid", {31'd0, IFID_Valid}, 32'd0);
      check32("mid_rst_pc", IFID_PC, 32'h0);
      check32("mid_rst_instr", IFID_Instr, 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3000, 1'b1, 1'b1, 32'h3000);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h3004, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h3004, 1'b1, 1'b0, 32'h0);

      check32("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
